rf_wb_queue: RTL

RF_WB_QUEUE -- requirements
Module: rf_wb_queue

---
 rtl/rf_wb_queue_pkg.sv | 18 +
 rtl/wb_fifo.sv | 79 +++++++
 rtl/rf_wb_queue.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rf_wb_queue_pkg.sv
// Shared register-file writeback definitions: datapath widths, entry payload, x0 check.
package rf_wb_queue_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    // One pending register-file write.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    // True when the register index addresses the hardwired-zero register.
    function automatic logic is_zero(input logic [REG_AW-1:0] idx);
        return idx == '0;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular storage for pending register-file writes with per-slot visibility.
module wb_fifo
    import rf_wb_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [PTR_W-1:0] rd_ptr,
    output wb_entry_t        head,
    output logic [DEPTH-1:0] vis,
    output wb_entry_t        entries [DEPTH]
);

    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    wb_entry_t        mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;
    logic [PTR_W-1:0] age;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign count   = count_q;
    assign rd_ptr  = rd_ptr_q;
    assign head    = mem_q[rd_ptr_q];
    assign entries = mem_q;

    // Pointer and occupancy bookkeeping; a concurrent push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Entry storage; contents are qualified by the visibility vector so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        vis = '0;
        age = '0;
        for (int unsigned s = 0; s < DEPTH; s++) begin
            age              = PTR_W'(s) - rd_ptr_q;
            vis[PTR_W'(s)]   = (CNT_W'(age) < count_q);
        end
    end

endmodule

// File: rtl/rf_wb_queue.sv
// Writeback queue: arbitrates ALU/LSU results into a FIFO that drains one
// register-file write per cycle, and forwards pending values to readers.
module rf_wb_queue
    import rf_wb_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic [REG_AW-1:0] p0_rd,
    input  logic [XLEN-1:0]   p0_data,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic [REG_AW-1:0] p1_rd,
    input  logic [XLEN-1:0]   p1_data,
    output logic              en4w,
    output logic [REG_AW-1:0] addr_w,
    output logic [XLEN-1:0]   data_i,
    input  logic [REG_AW-1:0] fw_addr0,
    input  logic [REG_AW-1:0] fw_addr1,
    output logic              fw_hit0,
    output logic              fw_hit1,
    output logic [XLEN-1:0]   fw_data0,
    output logic [XLEN-1:0]   fw_data1,
    output logic [CNT_W-1:0]  pending
);

    logic             prio_p1_q;
    logic             grant0;
    logic             grant1;
    logic             accept_ok;
    logic             xfer0;
    logic             xfer1;
    wb_entry_t        push_entry;
    logic             push;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] fifo_rd_ptr;
    wb_entry_t        fifo_head;
    logic [DEPTH-1:0] fifo_vis;
    wb_entry_t        fifo_entries [DEPTH];
    logic [PTR_W-1:0] slot;

    // Round-robin grant: contention goes to the producer not served last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (p0_valid && p1_valid) begin
            grant0 = !prio_p1_q;
            grant1 = prio_p1_q;
        end else begin
            grant0 = p0_valid;
            grant1 = p1_valid;
        end
    end

    // A full queue refuses everything, even in a cycle that also drains an entry.
    assign accept_ok = rst_n && !fifo_full;
    assign p0_ready  = grant0 && accept_ok;
    assign p1_ready  = grant1 && accept_ok;
    assign xfer0     = p0_valid && p0_ready;
    assign xfer1     = p1_valid && p1_ready;

    // Select the accepted result; writes to x0 are consumed but never stored.
    always_comb begin
        push_entry.rd   = p0_rd;
        push_entry.data = p0_data;
        if (xfer1) begin
            push_entry.rd   = p1_rd;
            push_entry.data = p1_data;
        end
    end

    assign push = (xfer0 || xfer1) && !is_zero(push_entry.rd);

    // Priority pointer moves only on an actual transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_p1_q <= 1'b0;
        end else if (xfer0) begin
            prio_p1_q <= 1'b1;
        end else if (xfer1) begin
            prio_p1_q <= 1'b0;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (!fifo_empty),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .rd_ptr     (fifo_rd_ptr),
        .head       (fifo_head),
        .vis        (fifo_vis),
        .entries    (fifo_entries)
    );

    // Head of queue drives the register-file write port every cycle it is occupied.
    assign en4w    = !fifo_empty;
    assign addr_w  = fifo_empty ? '0 : fifo_head.rd;
    assign data_i  = fifo_empty ? '0 : fifo_head.data;
    assign pending = fifo_count;

    // Forwarding scan from oldest to youngest so the youngest match wins.
    always_comb begin
        fw_hit0  = 1'b0;
        fw_hit1  = 1'b0;
        fw_data0 = '0;
        fw_data1 = '0;
        slot     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = fifo_rd_ptr + PTR_W'(i);
            if (fifo_vis[slot]) begin
                if (!is_zero(fw_addr0) && (fifo_entries[slot].rd == fw_addr0)) begin
                    fw_hit0  = 1'b1;
                    fw_data0 = fifo_entries[slot].data;
                end
                if (!is_zero(fw_addr1) && (fifo_entries[slot].rd == fw_addr1)) begin
                    fw_hit1  = 1'b1;
                    fw_data1 = fifo_entries[slot].data;
                end
            end
        end
    end

endmodule
